hamming_link_scheduler: RTL and testbench
=========================================

// Module: hamming_link_scheduler
// PURPOSE
//  Shares one Hamming(7,4) link (cc_encoder -> channel -> cc_decoder_ht) among N_REQ message sources.
//  - Arbitrates round-robin and launches one 4-bit message at a time.
//  - Holds the message stable until the decoded word returns.
//  - Retransmits on a decoder-flagged error and times out a lost word.
//  - Returns the codeword and a status to the owning requester.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  MSG_W      4   message width; must equal encoder input width
//  CODE_W     7   codeword width; must equal decoder output width
//  MAX_RETRY  2   retransmissions allowed after the first send
//  TIMEOUT    16  cycles allowed in WAIT_RX before TIMEOUT (link latency is 10)
// PORTS
//  clk            input   1             rising-edge clock
//  reset          input   1             asynchronous, active-low reset
//  req            input   N_REQ         request, held high until gnt
//  req_msg        input   N_REQ*MSG_W   message of requester i in bits [i*MSG_W +: MSG_W]
//  gnt            output  N_REQ         one-hot, 1-cycle pulse: req_msg[i] captured
//  done           output  N_REQ         one-hot, 1-cycle pulse: response for requester i valid
//  rsp_code       output  CODE_W        received codeword, valid with done
//  rsp_status     output  2             00 OK, 01 OK_RETRY, 10 ERR, 11 TIMEOUT; valid with done
//  busy           output  1             transaction in flight (state != IDLE)
//  encoder_ready  input   1             encoder accepts message when high
//  message        output  MSG_W         message to encoder
//  rx_valid       input   1             decoder output valid (1-cycle pulse)
//  error_det      input   1             decoder flagged error on this rx_valid
//  rx             input   CODE_W        decoder codeword
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; retry_cnt 0; timer 0.
//   Asserting reset mid-transaction aborts it immediately; no done is issued.
//  IDLE: if any req, grant winner the same cycle.
//   - Winner: first set req at or after rr_ptr, wrapping.
//   - gnt[w]=1; capture req_msg[w] into message; owner<=w.
//   - rr_ptr<=(w+1)%N_REQ; retry_cnt<=0; go SEND.
//   - req dropped before gnt: nothing captured.
//  SEND: wait for encoder_ready=1. The first such cycle is the launch; go WAIT_RX, timer<=0.
//  WAIT_RX: timer increments each cycle.
//   - rx_valid & !error_det: go RESP; status OK if retry_cnt==0, else OK_RETRY.
//   - rx_valid & error_det & retry_cnt<MAX_RETRY: retry_cnt++, go SEND (same message).
//   - rx_valid & error_det & retry_cnt==MAX_RETRY: go RESP, status ERR.
//   - timer==TIMEOUT-1 & !rx_valid: go DRAIN, status TIMEOUT.
//   - rx_valid on the same cycle as timeout expiry: rx_valid wins.
//  DRAIN: wait for encoder_ready=1, which guarantees the link is empty. Then go RESP.
//  RESP: one cycle.
//   - done[owner]=1; rsp_code=rx latched at the terminating rx_valid (0 on TIMEOUT); rsp_status.
//   - Next state IDLE; a new grant is possible the following cycle.
//  message is stable from capture until RESP, including across retries. This meets the
//   link's stable-input requirement while !encoder_ready.
//  rx_valid/error_det outside WAIT_RX are ignored (stale).
//  rsp_code/rsp_status hold their last value between done pulses; gnt/done are 0 otherwise.
//  Minimum transaction: IDLE(1)+SEND(>=1)+WAIT_RX(latency)+RESP(1).
//  Fairness: with all req held high, grants rotate 0,1,..,N_REQ-1,0.
//  Widths: timer $clog2(TIMEOUT) bits; retry_cnt $clog2(MAX_RETRY+1) bits; no overflow possible.
// STRUCTURE
//  hamming_link_pkg:
//   - MSG_W/CODE_W defaults.
//   - Enum link_status_e {ST_OK, ST_OK_RETRY, ST_ERR, ST_TIMEOUT}.
//   - Enum link_state_e {IDLE, SEND, WAIT_RX, DRAIN, RESP}.
//  Sub-module rr_arbiter #(N_REQ):
//   - Inputs: req, advance.
//   - Outputs: one-hot grant and index; owns rr_ptr.
//  Scheduler FSM, counters and data registers stay in this module.
// TESTING
//  1 Single req[0], msg 4'b1001, link clean (rx_valid 10 cycles after launch, error_det=0)
//    -> gnt[0] once; message=1001 stable; done[0] with rsp_status=00, rsp_code=rx.
//  2 req[0..3] all held, msgs 1,2,3,4
//    -> gnt order 0,1,2,3; each done precedes next gnt; message never changes inside a transaction.
//  3 error_det=1 on the first two rx_valid, 0 on the third (MAX_RETRY=2)
//    -> three launches of the same message; one done with status 01.
//  4 error_det=1 on three consecutive rx_valid -> done with status 10 after the third; no fourth launch.
//  5 rx_valid never asserted, encoder_ready returns 20 cycles after launch
//    -> DRAIN entered at timer 15; done with status 11 and rsp_code 0 after encoder_ready.
//  6 reset low during WAIT_RX, then a late rx_valid
//    -> outputs 0 immediately; late rx_valid ignored; next grant starts from requester 0.

Source files
------------

// File: rtl/hamming_link_pkg.sv
// -----------------------------------------------------------------------------
// hamming_link_pkg
//   Shared definitions for the Hamming(7,4) link scheduler: default message
//   and codeword widths, the response status encoding returned to requesters
//   and the scheduler state encoding.
// -----------------------------------------------------------------------------
package hamming_link_pkg;

  localparam int MSG_W_DEF  = 4;
  localparam int CODE_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_OK_RETRY = 2'b01,
    ST_ERR      = 2'b10,
    ST_TIMEOUT  = 2'b11
  } link_status_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_RX = 3'd2,
    DRAIN   = 3'd3,
    RESP    = 3'd4
  } link_state_e;

endpackage

// File: rtl/hamming_link_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. Picks the first asserted request at or after the
//   round-robin pointer (wrapping) and moves the pointer past the winner when
//   the grant is taken.
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset (pointer returns to 0)
//   req      in   N_REQ request vector
//   advance  in   grant is being taken this cycle; move pointer past winner
//   grant    out  one-hot winner (0 when no request)
//   index    out  binary index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter
  import hamming_link_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] rr_ptr;

  // Scan requesters starting at rr_ptr; the first hit wins, later hits are
  // masked by the found flag so grant stays one-hot.
  always_comb begin
    int               c;
    logic [IDX_W-1:0] cand;
    logic             found;
    grant = '0;
    index = '0;
    c     = 0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      cand = IDX_W'(c);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      if (index == IDX_W'(N_REQ - 1)) rr_ptr <= '0;
      else                            rr_ptr <= index + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_link_scheduler.sv
// -----------------------------------------------------------------------------
// hamming_link_scheduler
//   Shares one Hamming(7,4) link (encoder -> channel -> decoder) among N_REQ
//   message sources. Grants round-robin, holds the message stable for the
//   whole transaction, retransmits on decoder-flagged errors (up to MAX_RETRY
//   times), times out a lost word and drains the link, then returns the
//   received codeword and a status to the owning requester.
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   req, req_msg    request vector and packed per-requester messages
//   gnt             one-hot pulse: req_msg of that requester captured
//   done            one-hot pulse: response for that requester valid
//   rsp_code        received codeword (0 on timeout), valid with done
//   rsp_status      00 OK, 01 OK_RETRY, 10 ERR, 11 TIMEOUT, valid with done
//   busy            transaction in flight
//   encoder_ready   encoder accepts a message / link is empty
//   message         message presented to the encoder
//   rx_valid, error_det, rx   decoder result
// -----------------------------------------------------------------------------
module hamming_link_scheduler
  import hamming_link_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MSG_W     = MSG_W_DEF,
  parameter int CODE_W    = CODE_W_DEF,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*MSG_W-1:0] req_msg,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [CODE_W-1:0]      rsp_code,
  output logic [1:0]             rsp_status,
  output logic                   busy,
  input  logic                   encoder_ready,
  output logic [MSG_W-1:0]       message,
  input  logic                   rx_valid,
  input  logic                   error_det,
  input  logic [CODE_W-1:0]      rx
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SEND  = SEND;
  localparam logic [2:0] S_WAIT  = WAIT_RX;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_RESP  = RESP;

  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry_cnt;
  logic [IDX_W-1:0] owner;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_index;
  logic             arb_advance;
  logic [MSG_W-1:0] msg_arr [N_REQ];

  assign arb_advance = (state == S_IDLE) && (|req);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) msg_arr[i] = req_msg[i*MSG_W +: MSG_W];
  end

  // gnt is combinational from the arbiter so the winner is granted in the
  // same IDLE cycle; it is forced low while reset is held.
  assign gnt  = (reset && state == S_IDLE) ? arb_grant : '0;
  assign busy = (state != S_IDLE);

  always_comb begin
    done = '0;
    if (state == S_RESP) done[owner] = 1'b1;
  end

  // Scheduler FSM. rsp_code/rsp_status are loaded only on the transition into
  // RESP, so they hold their previous value for the rest of the transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      retry_cnt  <= '0;
      owner      <= '0;
      message    <= '0;
      rsp_code   <= '0;
      rsp_status <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            message   <= msg_arr[arb_index];
            owner     <= arb_index;
            retry_cnt <= '0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (encoder_ready) begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A decoder result arriving on the expiry cycle takes priority.
          if (rx_valid) begin
            if (!error_det) begin
              rsp_code   <= rx;
              rsp_status <= (retry_cnt == '0) ? ST_OK : ST_OK_RETRY;
              state      <= S_RESP;
            end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_SEND;
            end else begin
              rsp_code   <= rx;
              rsp_status <= ST_ERR;
              state      <= S_RESP;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            state <= S_DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN: begin
          // encoder_ready high means the lost word has left the link.
          if (encoder_ready) begin
            rsp_code   <= '0;
            rsp_status <= ST_TIMEOUT;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_link_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hamming_link_scheduler
//   Self-checking bench for hamming_link_scheduler. A link emulator plays the
//   encoder/channel/decoder (fixed 10-cycle latency, scripted errors or a
//   lost word), a transaction-level model predicts grants, message, done
//   timing and response, and a negedge compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_hamming_link_scheduler;

  localparam int N_REQ      = 4;
  localparam int MSG_W      = 4;
  localparam int CODE_W     = 7;
  localparam int MAX_RETRY  = 2;
  localparam int TIMEOUT    = 16;
  localparam int LINK_LAT   = 10;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*MSG_W-1:0] req_msg;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [CODE_W-1:0]      rsp_code;
  logic [1:0]             rsp_status;
  logic                   busy;
  logic                   encoder_ready;
  logic [MSG_W-1:0]       message;
  logic                   rx_valid;
  logic                   error_det;
  logic [CODE_W-1:0]      rx;

  hamming_link_scheduler #(
    .N_REQ(N_REQ), .MSG_W(MSG_W), .CODE_W(CODE_W),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
    .gnt(gnt), .done(done), .rsp_code(rsp_code), .rsp_status(rsp_status),
    .busy(busy), .encoder_ready(encoder_ready), .message(message),
    .rx_valid(rx_valid), .error_det(error_det), .rx(rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model / emulator shared state
  int          cyc = 0;
  int          fl = -1;
  bit          in_txn = 0;
  int          owner = 0;
  logic [3:0]  exp_msg = '0;
  int          mdl_rr = 0;
  bit          pend_valid = 0;
  int          pend_cyc = 0;
  bit          term_known = 0;
  int          exp_done_cyc = 0;
  logic [6:0]  exp_code = '0;
  logic [1:0]  exp_status = '0;
  logic [6:0]  held_code = '0;
  logic [1:0]  held_status = '0;
  int          txn_errs = 0;
  int          launches = 0;
  int          launch_cyc = 0;
  int          err_left = 0;
  bit          lost_mode = 0;
  int          lost_ready = 20;
  int          gnt_cyc = 0;
  int          done_cyc = 0;
  int          done_count = 0;
  int          gnt_order[$];
  bit          clear_req = 0;
  int          clear_idx = 0;
  logic [3:0]  launch_msg = '0;

  function automatic logic [6:0] ham_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Link emulator: launches a word on the first SEND cycle with encoder_ready,
  // keeps encoder_ready low while it is in flight and returns the decoded
  // word LINK_LAT cycles after launch, or drops it in lost_mode.
  initial begin
    bit   launched;
    logic err;
    encoder_ready = 1'b1;
    rx_valid      = 1'b0;
    error_det     = 1'b0;
    rx            = '0;
    forever begin
      @(posedge clk);
      launched = pend_valid && (cyc >= pend_cyc) && encoder_ready && reset && in_txn;
      cyc++;
      #1;
      rx_valid  = 1'b0;
      error_det = 1'b0;
      if (clear_req) begin
        req[2'(clear_idx)] = 1'b0;
        clear_req = 0;
      end
      if (launched) begin
        pend_valid    = 0;
        launches++;
        launch_cyc    = cyc - 1;
        fl            = 0;
        encoder_ready = 1'b0;
        launch_msg    = exp_msg;
      end else if (fl >= 0) begin
        fl++;
      end
      if (!lost_mode && fl == LINK_LAT - 1) begin
        err = (err_left > 0);
        if (err) err_left--;
        rx_valid      = 1'b1;
        error_det     = err;
        rx            = ham_encode(launch_msg) ^ (err ? 7'b0010000 : 7'b0000000);
        encoder_ready = 1'b1;
        fl            = -1;
        if (in_txn) begin
          if (err && txn_errs < MAX_RETRY) begin
            txn_errs++;
            pend_valid = 1;
            pend_cyc   = cyc + 1;
          end else begin
            term_known   = 1;
            exp_done_cyc = cyc + 1;
            exp_code     = rx;
            exp_status   = err ? 2'b10 : ((txn_errs == 0) ? 2'b00 : 2'b01);
          end
        end
      end else if (lost_mode && fl == lost_ready - 1) begin
        encoder_ready = 1'b1;
        fl            = -1;
        if (in_txn) begin
          // Timeout fires after TIMEOUT idle WAIT_RX cycles; the drain then
          // ends on the first cycle encoder_ready is seen high.
          term_known   = 1;
          exp_done_cyc = ((cyc > launch_cyc + TIMEOUT + 1) ? cyc : launch_cyc + TIMEOUT + 1) + 1;
          exp_code     = '0;
          exp_status   = 2'b11;
        end
      end
    end
  end

  // Compare process: every cycle, checks outputs against the model.
  always @(negedge clk) begin
    int         w;
    logic [1:0] ci;
    if (!reset) begin
      checkOutput("reset_outputs", 32'({gnt, done, busy, message, rsp_code, rsp_status}), 32'd0);
      in_txn      = 0;
      pend_valid  = 0;
      term_known  = 0;
      held_code   = '0;
      held_status = '0;
      mdl_rr      = 0;
    end else if (!in_txn) begin
      w = -1;
      for (int k = 0; k < N_REQ; k++) begin
        ci = 2'((mdl_rr + k) % N_REQ);
        if (w < 0 && req[ci]) w = int'(ci);
      end
      checkOutput("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("held_code", 32'(rsp_code), 32'(held_code));
      checkOutput("held_status", 32'(rsp_status), 32'(held_status));
      if (w >= 0) begin
        in_txn     = 1;
        owner      = w;
        exp_msg    = 4'(req_msg >> (MSG_W * w));
        mdl_rr     = (w + 1) % N_REQ;
        txn_errs   = 0;
        pend_valid = 1;
        pend_cyc   = cyc + 1;
        term_known = 0;
        gnt_cyc    = cyc;
        gnt_order.push_back(w);
        clear_req  = 1;
        clear_idx  = w;
      end
    end else begin
      checkOutput("busy_gnt", 32'(gnt), 32'd0);
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("message_stable", 32'(message), 32'(exp_msg));
      if (term_known && cyc == exp_done_cyc) begin
        checkOutput("done", 32'(done), 32'd1 << owner);
        checkOutput("rsp_code", 32'(rsp_code), 32'(exp_code));
        checkOutput("rsp_status", 32'(rsp_status), 32'(exp_status));
        held_code   = exp_code;
        held_status = exp_status;
        in_txn      = 0;
        done_cyc    = cyc;
        done_count++;
      end else begin
        checkOutput("early_done", 32'(done), 32'd0);
        checkOutput("held_code", 32'(rsp_code), 32'(held_code));
        checkOutput("held_status", 32'(rsp_status), 32'(held_status));
      end
    end
  end

  task automatic applyReset();
    @(posedge clk);
    #1;
    reset         = 1'b0;
    req           = '0;
    req_msg       = '0;
    err_left      = 0;
    lost_mode     = 0;
    fl            = -1;
    encoder_ready = 1'b1;
    gnt_order.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] msgs,
                               input int errs, input bit lost, input int lost_rdy);
    @(posedge clk);
    #1;
    req_msg    = msgs;
    err_left   = errs;
    lost_mode  = lost;
    lost_ready = lost_rdy;
    req        = mask;
  endtask

  task automatic waitDones(input int n, input int budget);
    int target;
    target = done_count + n;
    for (int i = 0; i < budget && done_count < target; i++) @(posedge clk);
    checkOutput("done_within_budget", 32'(done_count - target + n), 32'(n));
  endtask

  initial begin
    int l0;
    int d0;
    int base;
    reset   = 1'b0;
    req     = '0;
    req_msg = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: single request, clean link
    applyReset();
    l0 = launches;
    applyStimulus(4'b0001, 16'h0009, 0, 0, 20);
    waitDones(1, 100);
    repeat (3) @(posedge clk);
    checkOutput("t1_grants", 32'(gnt_order.size()), 32'd1);
    checkOutput("t1_latency", 32'(done_cyc - gnt_cyc), 32'd12);
    checkOutput("t1_code", 32'(rsp_code), 32'h4C);
    checkOutput("t1_status", 32'(rsp_status), 32'd0);
    checkOutput("t1_launches", 32'(launches - l0), 32'd1);

    // 2: all four requesters held, fairness
    applyReset();
    l0 = launches;
    applyStimulus(4'b1111, 16'h4321, 0, 0, 20);
    waitDones(4, 400);
    checkOutput("t2_grants", 32'(gnt_order.size()), 32'd4);
    for (int i = 0; i < gnt_order.size() && i < 4; i++)
      checkOutput("t2_order", 32'(gnt_order[i]), 32'(i));
    checkOutput("t2_last_code", 32'(rsp_code), 32'h2A);
    checkOutput("t2_launches", 32'(launches - l0), 32'd4);

    // 3: two errors then clean -> OK_RETRY
    applyReset();
    l0 = launches;
    applyStimulus(4'b0100, 16'h0A00, 2, 0, 20);
    waitDones(1, 200);
    checkOutput("t3_launches", 32'(launches - l0), 32'd3);
    checkOutput("t3_status", 32'(rsp_status), 32'd1);
    checkOutput("t3_code", 32'(rsp_code), 32'h52);
    checkOutput("t3_latency", 32'(done_cyc - gnt_cyc), 32'd34);

    // 4: three errors -> ERR, no fourth launch
    applyReset();
    l0 = launches;
    applyStimulus(4'b0010, 16'h0060, 3, 0, 20);
    waitDones(1, 200);
    repeat (30) @(posedge clk);
    checkOutput("t4_launches", 32'(launches - l0), 32'd3);
    checkOutput("t4_status", 32'(rsp_status), 32'd2);
    checkOutput("t4_code", 32'(rsp_code), 32'h23);
    checkOutput("t4_latency", 32'(done_cyc - gnt_cyc), 32'd34);

    // 5: lost word, encoder_ready back 20 cycles after launch
    applyReset();
    l0 = launches;
    applyStimulus(4'b1000, 16'hF000, 0, 1, 20);
    waitDones(1, 200);
    checkOutput("t5_status", 32'(rsp_status), 32'd3);
    checkOutput("t5_code", 32'(rsp_code), 32'd0);
    checkOutput("t5_latency", 32'(done_cyc - gnt_cyc), 32'd22);
    checkOutput("t5_launches", 32'(launches - l0), 32'd1);

    // 5b: encoder_ready returns exactly as DRAIN is entered
    applyReset();
    applyStimulus(4'b0001, 16'h0005, 0, 1, 17);
    waitDones(1, 200);
    checkOutput("t5b_status", 32'(rsp_status), 32'd3);
    checkOutput("t5b_latency", 32'(done_cyc - gnt_cyc), 32'd19);

    // 6: reset during WAIT_RX, late rx_valid ignored, pointer back to 0
    applyReset();
    l0 = launches;
    applyStimulus(4'b0100, 16'h0700, 0, 0, 20);
    for (int i = 0; i < 20 && launches == l0; i++) @(posedge clk);
    checkOutput("t6_launched", 32'(launches - l0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_clear", 32'({gnt, done, busy, message, rsp_code, rsp_status}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    d0 = done_count;
    repeat (15) @(posedge clk);
    checkOutput("t6_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("t6_idle", 32'(busy), 32'd0);
    base = gnt_order.size();
    applyStimulus(4'b1010, 16'hC030, 0, 0, 20);
    waitDones(2, 200);
    checkOutput("t6_grants", 32'(gnt_order.size() - base), 32'd2);
    if (gnt_order.size() >= base + 2) begin
      checkOutput("t6_first", 32'(gnt_order[base]), 32'd1);
      checkOutput("t6_second", 32'(gnt_order[base+1]), 32'd3);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete (got running, expected finished)");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
